// File: rtl/write_buffer.sv
// Write-through buffer between a cache controller and main memory.
// Accepted writes are queued in a circular FIFO and drained to memory in
// acceptance order by a two-state drain machine. A read probe forwards the
// newest buffered copy of an address so a cache miss never sees stale memory.
module write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_req,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_hit,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } drain_state_t;

    // Entry storage and FIFO bookkeeping
    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    // Drain machine and the registered memory-side presentation
    drain_state_t      state_r;
    drain_state_t      state_next_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    // Per-cycle decode
    logic              wr_ready_s;
    logic              push_s;
    logic              pop_s;
    logic [PTR_W-1:0]  head_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [ADDR_W-1:0] load_addr_s;
    logic [DATA_W-1:0] load_data_s;

    // Forwarding
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;
    logic [PTR_W-1:0]  fwd_idx_s;

    // Accept/pop qualification; readiness comes only from registered count
    always_comb begin
        wr_ready_s = (count_r != CNT_W'(DEPTH));
        push_s     = wr_req && wr_ready_s;
        pop_s      = (state_r == BUSY) && mem_ack;
    end

    // Occupancy and head pointer after this edge's push/pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            head_next_s = head_r + PTR_W'(1);
        end else begin
            head_next_s = head_r;
        end
    end

    // Drain FSM next-state: leave IDLE when anything is queued, return when empty
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (count_r != CNT_W'(0)) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (pop_s) begin
                    if (count_next_s != CNT_W'(0)) begin
                        state_next_s = BUSY;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = BUSY;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Select the entry that will be at head after this edge; when the only
    // remaining entry is the one being pushed right now, take it from the port
    always_comb begin
        load_addr_s = addr_mem_r[head_next_s];
        load_data_s = data_mem_r[head_next_s];
        if (push_s && (tail_r == head_next_s)) begin
            load_addr_s = wr_addr;
            load_data_s = wr_data;
        end else begin
            load_addr_s = addr_mem_r[head_next_s];
            load_data_s = data_mem_r[head_next_s];
        end
    end

    // Drain state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory address/data registers: hold the head entry while BUSY, zero otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else if (state_next_s == BUSY) begin
            mem_addr_r  <= load_addr_s;
            mem_wdata_r <= load_data_s;
        end else begin
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_next_s;
            count_r <= count_next_s;
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end else begin
                tail_r <= tail_r;
            end
        end
    end

    // Entry storage, written at tail on an accepted push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= '0;
                data_mem_r[i] <= '0;
            end
        end else if (push_s) begin
            addr_mem_r[tail_r] <= wr_addr;
            data_mem_r[tail_r] <= wr_data;
        end else begin
            addr_mem_r[tail_r] <= addr_mem_r[tail_r];
            data_mem_r[tail_r] <= data_mem_r[tail_r];
        end
    end

    // Read-probe forwarding: walk oldest to newest so the newest match wins;
    // only entries inside the valid window (head .. head+count-1) participate
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = '0;
        fwd_idx_s  = head_r;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx_s = head_r + PTR_W'(k);
            if ((CNT_W'(k) < count_r) && (addr_mem_r[fwd_idx_s] == rd_addr)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = data_mem_r[fwd_idx_s];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign wr_ready  = wr_ready_s;
    assign rd_hit    = fwd_hit_s;
    assign rd_data   = fwd_data_s;
    assign mem_req   = (state_r == BUSY);
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign count     = count_r;
    assign empty     = (count_r == CNT_W'(0));

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer (DEPTH=4, ADDR_W=10, DATA_W=32).
module tb_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              reset_n;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [CNT_W-1:0]  count;
    logic              empty;

    int tests_run    = 0;
    int tests_failed = 0;

    write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_addr   (rd_addr),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .count     (count),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_req  = 1'b0;
    endtask

    // Wait (bounded) for mem_req, check presented entry, then ack it for one edge
    task automatic ack_check(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        while (!mem_req && n < 10) begin
            tick();
            n++;
        end
        check_eq({tag, "_req"}, mem_req, 1'b1);
        check_eq({tag, "_addr"}, mem_addr, a);
        check_eq({tag, "_data"}, mem_wdata, d);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count", count, 3'd0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 10'h000);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_wr_ready", wr_ready, 1'b1);
        check_eq("rst_empty", empty, 1'b1);
        check_eq("rst_rd_hit", rd_hit, 1'b0);
        check_eq("rst_rd_data", rd_data, 32'h0);
        #2 reset_n = 1'b1;
        tick();

        // Single write: count after one edge, mem_req one edge later, ack after 3 cycles
        push_one(10'h010, 32'hAAAA0001);
        check_eq("single_count", count, 3'd1);
        check_eq("single_req_early", mem_req, 1'b0);
        check_eq("single_not_empty", empty, 1'b0);
        tick();
        check_eq("single_req", mem_req, 1'b1);
        check_eq("single_addr", mem_addr, 10'h010);
        check_eq("single_data", mem_wdata, 32'hAAAA0001);
        tick();
        tick();
        check_eq("single_addr_hold", mem_addr, 10'h010);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("single_done_count", count, 3'd0);
        check_eq("single_done_empty", empty, 1'b1);
        check_eq("single_done_req", mem_req, 1'b0);

        // Fill: five back-to-back pushes with no ack, fifth is dropped
        for (int i = 0; i < 5; i++) begin
            wr_req  = 1'b1;
            wr_addr = 10'h100 + 10'(i);
            wr_data = 32'hB0000000 + 32'(i);
            tick();
            if (i == 2) check_eq("fill_ready_3", wr_ready, 1'b1);
            if (i == 3) check_eq("fill_ready_4", wr_ready, 1'b0);
        end
        wr_req = 1'b0;
        check_eq("fill_count", count, 3'd4);
        check_eq("fill_head_addr", mem_addr, 10'h100);
        // Full: push and ack on the same edge, push refused, pop happens
        wr_req  = 1'b1;
        wr_addr = 10'h1FF;
        wr_data = 32'hDEADDEAD;
        mem_ack = 1'b1;
        tick();
        wr_req  = 1'b0;
        mem_ack = 1'b0;
        check_eq("full_pushpop_count", count, 3'd3);
        ack_check("fill_d1", 10'h101, 32'hB0000001);
        ack_check("fill_d2", 10'h102, 32'hB0000002);
        ack_check("fill_d3", 10'h103, 32'hB0000003);
        check_eq("fill_drained", count, 3'd0);
        check_eq("fill_idle", mem_req, 1'b0);

        // Forwarding: newest match wins, miss returns zero, same-cycle push not forwarded
        push_one(10'h020, 32'h1);
        push_one(10'h020, 32'h2);
        rd_addr = 10'h020;
        #1;
        check_eq("fwd_hit", rd_hit, 1'b1);
        check_eq("fwd_newest", rd_data, 32'h2);
        rd_addr = 10'h021;
        #1;
        check_eq("fwd_miss_hit", rd_hit, 1'b0);
        check_eq("fwd_miss_data", rd_data, 32'h0);
        rd_addr = 10'h030;
        wr_req  = 1'b1;
        wr_addr = 10'h030;
        wr_data = 32'h3;
        #1;
        check_eq("fwd_same_cycle", rd_hit, 1'b0);
        tick();
        wr_req = 1'b0;
        check_eq("fwd_after_edge_hit", rd_hit, 1'b1);
        check_eq("fwd_after_edge_data", rd_data, 32'h3);
        ack_check("fwd_d0", 10'h020, 32'h1);
        ack_check("fwd_d1", 10'h020, 32'h2);
        ack_check("fwd_d2", 10'h030, 32'h3);
        check_eq("fwd_popped_miss", rd_hit, 1'b0);

        // Count=2 with push and ack on the same edge
        push_one(10'h040, 32'h40);
        push_one(10'h041, 32'h41);
        check_eq("pp2_req", mem_req, 1'b1);
        check_eq("pp2_count_pre", count, 3'd2);
        wr_req  = 1'b1;
        wr_addr = 10'h042;
        wr_data = 32'h42;
        mem_ack = 1'b1;
        tick();
        wr_req  = 1'b0;
        mem_ack = 1'b0;
        check_eq("pp2_count", count, 3'd2);
        ack_check("pp2_d1", 10'h041, 32'h41);
        ack_check("pp2_d2", 10'h042, 32'h42);
        check_eq("pp2_drained", count, 3'd0);

        // Count=1 with push and ack: the newly pushed entry becomes head at once
        push_one(10'h050, 32'h50);
        tick();
        check_eq("pp1_req", mem_req, 1'b1);
        wr_req  = 1'b1;
        wr_addr = 10'h051;
        wr_data = 32'h51;
        mem_ack = 1'b1;
        tick();
        wr_req  = 1'b0;
        mem_ack = 1'b0;
        check_eq("pp1_count", count, 3'd1);
        check_eq("pp1_req_stay", mem_req, 1'b1);
        ack_check("pp1_d", 10'h051, 32'h51);
        check_eq("pp1_drained", count, 3'd0);

        // Pointer wrap: nine push/ack rounds
        for (int i = 0; i < 9; i++) begin
            push_one(10'h200 + 10'(i), 32'hC0DE0000 + 32'(i));
            ack_check("wrap", 10'h200 + 10'(i), 32'hC0DE0000 + 32'(i));
        end
        check_eq("wrap_drained", count, 3'd0);

        // Reset while BUSY with three entries
        push_one(10'h300, 32'h300);
        push_one(10'h301, 32'h301);
        push_one(10'h302, 32'h302);
        check_eq("rst_busy_count", count, 3'd3);
        check_eq("rst_busy_req", mem_req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_req", mem_req, 1'b0);
        check_eq("arst_count", count, 3'd0);
        check_eq("arst_empty", empty, 1'b1);
        check_eq("arst_addr", mem_addr, 10'h000);
        tick();
        #2 reset_n = 1'b1;
        mem_ack = 1'b1;
        repeat (3) tick();
        mem_ack = 1'b0;
        check_eq("post_rst_count", count, 3'd0);
        check_eq("post_rst_req", mem_req, 1'b0);
        check_eq("post_rst_ready", wr_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
